axi_master_ofm: RTL and testbench
=================================

# axi_master_ofm

AXI4 write-burst master that drains the output-feature-map (OFM) buffer to external memory; the write-direction counterpart of the IFM read master. One `start_write` moves `BURST_LEN` beats from the OFM buffer, addresses `0..BURST_LEN-1`, to `base_addr` as a single INCR burst. It then waits for the write response and pulses `done`. It sits between the layer controller and the AXI interconnect.

## Interface
Parameters:
- `AXI_ADDR_W`, 32: AXI address width.
- `AXI_DATA_W`, 128: AXI data width and OFM buffer word width.
- `BUF_ADDR_W`, 10: OFM buffer address width; must satisfy 2^BUF_ADDR_W ≥ BURST_LEN.
- `BURST_LEN`, 128: beats per burst, 1..256.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `start_write` in 1: pulse that starts a burst; sampled only in IDLE.
- `base_addr` in AXI_ADDR_W: burst start address, captured in IDLE.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: sticky write-response error (see Configuration).
- `awaddr` out AXI_ADDR_W; `awlen` out 8; `awsize` out 3; `awburst` out 2: AXI write-address channel fields.
- `awvalid` out 1; `awready` in 1: write-address handshake.
- `wdata` out AXI_DATA_W; `wstrb` out AXI_DATA_W/8; `wlast` out 1: AXI write-data channel fields.
- `wvalid` out 1; `wready` in 1: write-data handshake.
- `bresp` in 2; `bvalid` in 1; `bready` out 1: write-response channel.
- `rd_en` out 1; `rd_addr` out BUF_ADDR_W: OFM buffer read request.
- `rd_data` in AXI_DATA_W: buffer read data, valid exactly one cycle after `rd_en`.

## Operation
- FSM states: IDLE, ADDR, DATA, RESP, DONE.
  - IDLE→ADDR on `start_write`.
  - ADDR→DATA on `awvalid && awready`.
  - DATA→RESP on `wvalid && wready && wlast`.
  - RESP→DONE on `bvalid`.
  - DONE→IDLE unconditionally.
- In IDLE, the block registers `awaddr`=`base_addr`, `awlen`=BURST_LEN-1, `awsize`=clog2(AXI_DATA_W/8), and `awburst`=2'b01. It also clears the read pointer and beat counter.
- `start_write` outside IDLE is ignored and not queued.
- Prefetch: a 2-entry FIFO holds buffer words.
  - `rd_en` is asserted from ADDR onward while issued reads < BURST_LEN and (occupancy + in-flight − pop this cycle) < 2.
  - `rd_addr` increments per issued read: 0, 1, …, BURST_LEN-1.
  - Sustains one beat per cycle under continuous `wready`.
- `wvalid` is asserted only in DATA with the FIFO non-empty; `wdata` is the FIFO head.
- `wstrb` is all ones.
- The beat counter increments on each W handshake; `wlast`=1 exactly on beat BURST_LEN-1.
- `bready`=1 only in RESP.
- `done`=1 for exactly the cycle the FSM is in DONE.
- `err` is cleared on `start_write` accepted in IDLE.

## Timing
- Reset values, all 0: `awaddr`, `awvalid`, `awlen`, `awsize`, `awburst`, `wdata`, `wstrb`, `wvalid`, `wlast`, `bready`, `rd_en`, `rd_addr`, `done`, `err`. FIFO is emptied and counters zeroed.
- Start latency: `start_write` in cycle 0 → `awvalid`=1 in cycle 1.
- With `awready`=1 in cycle 1: `rd_en` in cycle 1, FIFO write in cycle 2, first `wvalid` in cycle 3.
- Once asserted, `awvalid` holds with stable fields until `awready`.
- Once asserted, `wvalid` holds with stable `wdata`/`wlast` until `wready`. No bubble is inserted while `wready`=1.
- `wready` low stalls the beat; prefetch stops at a full FIFO and no word is lost or duplicated.
- `bvalid` arriving before RESP is not accepted, because `bready`=0.
- `rst` mid-burst aborts immediately with all outputs at reset values. The interconnect must be reset with the block.
- BURST_LEN=1: a single beat with `wlast`=1, `awlen`=0.

## Configuration
- Macro `AXI_MASTER_OFM_BRESP_CHECK_EN`.
- Defined: `err` is set at the `bvalid` handshake if `bresp`≠2'b00 and holds until the next accepted start.
- Undefined: `bresp` is ignored and `err` is tied 0.
- FSM behaviour is identical in both cases.

## Structure
- Shared package: FSM state encoding, AXI burst/resp constants (INCR=2'b01, OKAY=2'b00).
- One sub-module: `ofm_prefetch_fifo`, 2-entry synchronous FIFO with push/pop/count, both permitted in the same cycle.

## Test plan
- Burst with `wready`, `awready`, `bvalid` always 1; BURST_LEN=128; buffer word i = i; `base_addr`=0x1000_0000:
  - `awaddr`=0x1000_0000, `awlen`=127, `awsize`=4, `awburst`=1.
  - 128 contiguous beats with `wdata`=0..127, `wlast` only on the 128th.
  - One `done` pulse.
- `wready` toggling 1/0 every cycle: data order 0..127 is preserved, no duplicates, `wvalid`/`wdata` stable while stalled.
- `awready` delayed 5 cycles: `awvalid` is held 6 cycles and no `wvalid` appears before the AW handshake.
- `bvalid` with `bresp`=2'b10, macro defined: `err`=1 after the response and `done` still pulses. With the macro undefined, `err`=0.
- `rst` at beat 40, then a new start:
  - all outputs return to 0 within the reset cycle;
  - the next burst restarts at `rd_addr` 0 and completes normally.
- `start_write` asserted in DATA: ignored; exactly one burst is issued.

Source files
------------

// File: rtl/axi_master_ofm_pkg.sv
// Shared definitions for the OFM write-burst master: FSM state encoding,
// AXI burst/response constants and the prefetch FIFO depth.
package axi_master_ofm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RESP,
        ST_DONE
    } state_e;

    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
    localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
    localparam int unsigned FIFO_DEPTH     = 2;

    // AXI AxSIZE encoding for a beat of the given number of bytes.
    function automatic logic [2:0] axi_size(input int unsigned bytes);
        return 3'($clog2(bytes));
    endfunction

endpackage

// File: rtl/axi_master_ofm_prefetch_fifo.sv
// Two-entry synchronous FIFO holding OFM buffer words ahead of the AXI
// write-data channel. Push and pop may happen in the same cycle; the
// caller guarantees it never pushes into a full FIFO.
module ofm_prefetch_fifo
    import axi_master_ofm_pkg::*;
#(
    parameter int unsigned DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] data_o,
    output logic [1:0]        count_o
);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        count_q;

    // Storage, ring pointers and occupancy tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/axi_master_ofm.sv
// AXI4 write-burst master draining the OFM buffer to external memory.
// One start_write issues a single INCR burst of BURST_LEN beats read from
// buffer addresses 0..BURST_LEN-1, waits for the write response and
// pulses done.
// Optional feature macro: AXI_MASTER_OFM_BRESP_CHECK_EN -- when defined,
// a non-OKAY bresp sets the sticky err flag; otherwise err is tied low.
module axi_master_ofm
    import axi_master_ofm_pkg::*;
#(
    parameter int unsigned AXI_ADDR_W = 32,
    parameter int unsigned AXI_DATA_W = 128,
    parameter int unsigned BUF_ADDR_W = 10,
    parameter int unsigned BURST_LEN  = 128
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_write,
    input  logic [AXI_ADDR_W-1:0]   base_addr,
    output logic                    done,
    output logic                    err,
    output logic [AXI_ADDR_W-1:0]   awaddr,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [AXI_DATA_W-1:0]   wdata,
    output logic [AXI_DATA_W/8-1:0] wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready,
    output logic                    rd_en,
    output logic [BUF_ADDR_W-1:0]   rd_addr,
    input  logic [AXI_DATA_W-1:0]   rd_data
);

    localparam int unsigned STRB_W     = AXI_DATA_W / 8;
    localparam logic [8:0]  BURST_CNT  = 9'(BURST_LEN);
    localparam logic [8:0]  LAST_BEAT  = 9'(BURST_LEN - 1);
    localparam logic [7:0]  AWLEN_VAL  = 8'(BURST_LEN - 1);
    localparam logic [2:0]  AWSIZE_VAL = axi_size(STRB_W);

    state_e                  state_q;
    logic [AXI_ADDR_W-1:0]   awaddr_q;
    logic [7:0]              awlen_q;
    logic [2:0]              awsize_q;
    logic [1:0]              awburst_q;
    logic                    awvalid_q;
    logic                    bready_q;
    logic                    done_q;

    logic [8:0]              issued_q;
    logic [8:0]              beat_q;
    logic [BUF_ADDR_W-1:0]   rd_addr_q;
    logic                    rd_en_q;
    logic                    rd_en_d;

    logic [AXI_DATA_W-1:0]   fifo_head;
    logic [1:0]              fifo_count;
    logic                    w_fire;

`ifdef AXI_MASTER_OFM_BRESP_CHECK_EN
    logic err_q;
    assign err = err_q;
`else
    logic unused_bresp;
    assign unused_bresp = ^bresp;
    assign err          = 1'b0;
`endif

    // Write-data channel is driven straight from the FIFO head.
    assign wvalid  = (state_q == ST_DATA) && (fifo_count != 2'd0);
    assign wdata   = fifo_head;
    assign wstrb   = {STRB_W{wvalid}};
    assign wlast   = wvalid && (beat_q == LAST_BEAT);
    assign w_fire  = wvalid && wready;

    assign awaddr  = awaddr_q;
    assign awlen   = awlen_q;
    assign awsize  = awsize_q;
    assign awburst = awburst_q;
    assign awvalid = awvalid_q;
    assign bready  = bready_q;
    assign done    = done_q;
    assign rd_en   = rd_en_d;
    assign rd_addr = rd_addr_q;

    // Issue a buffer read while reads remain and the word will have a FIFO
    // slot: occupancy plus the read already in flight, less this cycle's pop.
    always_comb begin
        rd_en_d = 1'b0;
        if ((state_q == ST_ADDR || state_q == ST_DATA) && (issued_q < BURST_CNT)) begin
            rd_en_d = ({1'b0, fifo_count} + {2'b00, rd_en_q}) < (3'd2 + {2'b00, w_fire});
        end
    end

    // Burst control FSM with registered AW/B channel outputs and status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            awaddr_q  <= '0;
            awlen_q   <= '0;
            awsize_q  <= '0;
            awburst_q <= '0;
            awvalid_q <= 1'b0;
            bready_q  <= 1'b0;
            done_q    <= 1'b0;
`ifdef AXI_MASTER_OFM_BRESP_CHECK_EN
            err_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start_write) begin
                        awaddr_q  <= base_addr;
                        awlen_q   <= AWLEN_VAL;
                        awsize_q  <= AWSIZE_VAL;
                        awburst_q <= AXI_BURST_INCR;
                        awvalid_q <= 1'b1;
                        state_q   <= ST_ADDR;
`ifdef AXI_MASTER_OFM_BRESP_CHECK_EN
                        err_q     <= 1'b0;
`endif
                    end
                end
                ST_ADDR: begin
                    if (awvalid_q && awready) begin
                        awvalid_q <= 1'b0;
                        state_q   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_fire && wlast) begin
                        bready_q <= 1'b1;
                        state_q  <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bvalid) begin
                        bready_q <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= ST_DONE;
`ifdef AXI_MASTER_OFM_BRESP_CHECK_EN
                        if (bresp != AXI_RESP_OKAY) begin
                            err_q <= 1'b1;
                        end
`endif
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Read pointer, issued-read and beat counters; cleared while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issued_q  <= '0;
            beat_q    <= '0;
            rd_addr_q <= '0;
            rd_en_q   <= 1'b0;
        end else begin
            rd_en_q <= rd_en_d;
            if (state_q == ST_IDLE) begin
                issued_q  <= '0;
                beat_q    <= '0;
                rd_addr_q <= '0;
            end else begin
                if (rd_en_d) begin
                    issued_q  <= issued_q + 9'd1;
                    rd_addr_q <= rd_addr_q + BUF_ADDR_W'(1);
                end
                if (w_fire) begin
                    beat_q <= beat_q + 9'd1;
                end
            end
        end
    end

    ofm_prefetch_fifo #(
        .DATA_W (AXI_DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (rd_en_q),
        .data_i  (rd_data),
        .pop_i   (w_fire),
        .data_o  (fifo_head),
        .count_o (fifo_count)
    );

endmodule

// File: tb/tb_axi_master_ofm.sv
// Self-checking bench for axi_master_ofm: table of burst scenarios with
// randomized data, addresses and handshake timing, checked against a
// burst-level reference (expected beat stream, AW fields, latencies),
// plus a mid-burst reset sequence.
module tb_axi_master_ofm;

    localparam int AW = 32;
    localparam int DW = 128;
    localparam int BAW = 10;
    localparam int BL = 128;
    localparam int SW = DW / 8;
`ifdef AXI_MASTER_OFM_BRESP_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start_write;
    logic [AW-1:0] base_addr;
    logic          done, err;
    logic [AW-1:0] awaddr;
    logic [7:0]    awlen;
    logic [2:0]    awsize;
    logic [1:0]    awburst;
    logic          awvalid, awready;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          wlast, wvalid, wready;
    logic [1:0]    bresp;
    logic          bvalid, bready;
    logic          rd_en;
    logic [BAW-1:0] rd_addr;
    logic [DW-1:0] rd_data;

    axi_master_ofm #(
        .AXI_ADDR_W (AW),
        .AXI_DATA_W (DW),
        .BUF_ADDR_W (BAW),
        .BURST_LEN  (BL)
    ) dut (
        .clk (clk), .rst (rst), .start_write (start_write), .base_addr (base_addr),
        .done (done), .err (err),
        .awaddr (awaddr), .awlen (awlen), .awsize (awsize), .awburst (awburst),
        .awvalid (awvalid), .awready (awready),
        .wdata (wdata), .wstrb (wstrb), .wlast (wlast), .wvalid (wvalid), .wready (wready),
        .bresp (bresp), .bvalid (bvalid), .bready (bready),
        .rd_en (rd_en), .rd_addr (rd_addr), .rd_data (rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] base;
        int          aw_delay;
        int          w_mode;     // 0 always ready, 1 toggle, 2 random
        bit          b_early;    // bvalid held high from the start
        int          b_delay;
        logic [1:0]  bresp;
        bit          start_in_data;
        bit          ramp;
        bit          exp_err;
        int          exp_wlat;
    } vec_t;

    // OFM buffer model: read data one cycle after rd_en, garbage otherwise.
    logic [DW-1:0] mem [0:BL-1];
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
        else       rd_data <= {$urandom, $urandom, $urandom, $urandom};
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Monitor state
    bit            mon_en = 1'b0;
    int            aw_cycles, aw_hs, aw_viol, early_w, strb_viol, stall_viol;
    int            rd_viol, rd_exp, b_hs, bready_early, done_cnt;
    int            first_w, first_hs, last_hs, start_cyc;
    logic [AW-1:0] cap_awaddr;
    logic [7:0]    cap_awlen;
    logic [2:0]    cap_awsize;
    logic [1:0]    cap_awburst;
    logic [DW-1:0] got_q [$];
    bit            last_q [$];
    logic          p_awv, p_awr, p_wv, p_wr, p_wlast;
    logic [AW-1:0] p_awaddr;
    logic [DW-1:0] p_wdata;
    int            aw_seen, b_seen;

    task automatic clear_mon();
        aw_cycles = 0; aw_hs = 0; aw_viol = 0; early_w = 0; strb_viol = 0;
        stall_viol = 0; rd_viol = 0; rd_exp = 0; b_hs = 0; bready_early = 0;
        done_cnt = 0; first_w = -1; first_hs = -1; last_hs = -1;
        got_q.delete(); last_q.delete();
        p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_wlast = 0;
        p_awaddr = '0; p_wdata = '0;
    endtask

    // Protocol monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (wvalid && aw_hs == 0) early_w++;
            if (awvalid) aw_cycles++;
            if (p_awv && !p_awr && (!awvalid || awaddr != p_awaddr)) aw_viol++;
            if (awvalid && awready) begin
                aw_hs++;
                cap_awaddr = awaddr; cap_awlen = awlen; cap_awsize = awsize; cap_awburst = awburst;
            end
            if (wvalid) begin
                if (first_w < 0) first_w = cyc;
                if (wstrb != {SW{1'b1}}) strb_viol++;
            end
            if (p_wv && !p_wr && (!wvalid || wdata != p_wdata || wlast != p_wlast)) stall_viol++;
            if (wvalid && wready) begin
                got_q.push_back(wdata);
                last_q.push_back(wlast);
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
            end
            if (rd_en) begin
                if (int'(rd_addr) != rd_exp) rd_viol++;
                rd_exp++;
            end
            if (bready && got_q.size() < BL) bready_early++;
            if (bvalid && bready) b_hs++;
            if (done) done_cnt++;
            p_awv = awvalid; p_awr = awready; p_awaddr = awaddr;
            p_wv = wvalid; p_wr = wready; p_wdata = wdata; p_wlast = wlast;
        end
    end

    // Per-cycle handshake stimulus for one scenario.
    task automatic drive(input vec_t v, input int k);
        awready = awvalid && (aw_seen >= v.aw_delay);
        if (awvalid) aw_seen++;
        case (v.w_mode)
            0:       wready = 1'b1;
            1:       wready = k[0];
            default: wready = 1'($urandom_range(0, 1));
        endcase
        if (v.b_early) bvalid = 1'b1;
        else begin
            bvalid = bready && (b_seen >= v.b_delay);
            if (bready) b_seen++;
        end
        bresp = v.bresp;
        start_write = v.start_in_data && (got_q.size() >= 2) && (got_q.size() < 5);
    endtask

    task automatic start_burst(input vec_t v);
        for (int i = 0; i < BL; i++)
            mem[i] = v.ramp ? DW'(i) : {$urandom, $urandom, $urandom, $urandom};
        clear_mon();
        mon_en = 1'b1;
        @(posedge clk); #1;
        base_addr = v.base;
        start_write = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start_write = 1'b0;
        base_addr = $urandom;
        aw_seen = 0;
        b_seen = 0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int k, nlast, lastpos, bad;
        string p;
        p = $sformatf("v%0d", idx);
        start_burst(v);
        k = 1;
        drive(v, k);
        while (done_cnt == 0 && k < 4000) begin
            @(posedge clk); #1;
            k++;
            drive(v, k);
        end
        chk({p, "_done_seen"}, 128'(done_cnt != 0), 1);
        awready = 0; wready = 0; bvalid = 0; start_write = 0;
        repeat (10) @(posedge clk);
        #1;
        mon_en = 1'b0;

        nlast = 0; lastpos = -1; bad = 0;
        foreach (last_q[i]) if (last_q[i]) begin nlast++; lastpos = i; end
        for (int i = 0; i < got_q.size() && i < BL; i++)
            if (got_q[i] !== mem[i]) bad++;

        chk({p, "_done_pulses"},   128'(done_cnt), 1);
        chk({p, "_aw_handshakes"}, 128'(aw_hs), 1);
        chk({p, "_awvalid_cycles"},128'(aw_cycles), 128'(v.aw_delay + 1));
        chk({p, "_aw_stable"},     128'(aw_viol), 0);
        chk({p, "_awaddr"},        128'(cap_awaddr), 128'(v.base));
        chk({p, "_awlen"},         128'(cap_awlen), 128'(BL - 1));
        chk({p, "_awsize"},        128'(cap_awsize), 128'($clog2(SW)));
        chk({p, "_awburst"},       128'(cap_awburst), 1);
        chk({p, "_w_before_aw"},   128'(early_w), 0);
        chk({p, "_first_w_lat"},   128'(first_w - start_cyc), 128'(v.exp_wlat));
        chk({p, "_beats"},         128'(got_q.size()), 128'(BL));
        chk({p, "_data_mismatch"}, 128'(bad), 0);
        chk({p, "_wlast_count"},   128'(nlast), 1);
        chk({p, "_wlast_pos"},     128'(lastpos), 128'(BL - 1));
        chk({p, "_w_stall_stable"},128'(stall_viol), 0);
        chk({p, "_wstrb"},         128'(strb_viol), 0);
        chk({p, "_reads"},         128'(rd_exp), 128'(BL));
        chk({p, "_rd_addr_order"}, 128'(rd_viol), 0);
        chk({p, "_bready_early"},  128'(bready_early), 0);
        chk({p, "_b_handshakes"},  128'(b_hs), 1);
        chk({p, "_err"},           128'(err), 128'(v.exp_err));
        if (v.w_mode == 0)
            chk({p, "_contiguous"}, 128'(last_hs - first_hs), 128'(BL - 1));
    endtask

    function automatic vec_t mk(input logic [31:0] base, input int d, input int wm, input bit be,
                                input int bd, input logic [1:0] br, input bit sid, input bit ramp);
        vec_t v;
        v.base = base; v.aw_delay = d; v.w_mode = wm; v.b_early = be; v.b_delay = bd;
        v.bresp = br; v.start_in_data = sid; v.ramp = ramp;
        v.exp_err  = CHK_EN && (br != 2'b00);
        v.exp_wlat = (d == 0) ? 3 : 2 + d;   // AW handshake gates DATA; prefetch needs 2 cycles
        return v;
    endfunction

    vec_t vecs [8];

    initial begin
        int k;
        vec_t vr;
        vecs[0] = mk(32'h1000_0000, 0, 0, 1'b1, 0, 2'b00, 1'b0, 1'b1);
        vecs[1] = mk(32'h2000_0000, 0, 1, 1'b0, 2, 2'b00, 1'b0, 1'b1);
        vecs[2] = mk(32'h3000_0040, 5, 0, 1'b0, 0, 2'b00, 1'b0, 1'b0);
        vecs[3] = mk(32'h4000_1000, 1, 2, 1'b0, 3, 2'b10, 1'b0, 1'b0);
        vecs[4] = mk(32'h5000_0000, 0, 0, 1'b1, 0, 2'b00, 1'b1, 1'b0);
        for (int i = 5; i < 8; i++)
            vecs[i] = mk($urandom, $urandom_range(0, 4), 2, 1'($urandom_range(0, 1)),
                         $urandom_range(0, 3), 2'($urandom_range(0, 3)), 1'b0, 1'b0);

        rst = 1'b1; start_write = 0; base_addr = '0; awready = 0; wready = 0;
        bresp = 2'b00; bvalid = 0;
        #1;
        chk("reset_outputs_zero",
            128'(|{awaddr, awvalid, awlen, awsize, awburst, wdata, wstrb, wvalid, wlast,
                   bready, rd_en, rd_addr, done, err}), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Mid-burst reset at beat 40, then a clean restart.
        vr = mk(32'h6000_0000, 0, 0, 1'b0, 1, 2'b00, 1'b0, 1'b1);
        start_burst(vr);
        k = 1;
        drive(vr, k);
        while (got_q.size() < 40 && k < 2000) begin
            @(posedge clk); #1;
            k++;
            drive(vr, k);
        end
        chk("rst_reach_beat40", 128'(got_q.size() >= 40), 1);
        rst = 1'b1;
        #1;
        chk("rst_mid_outputs_zero",
            128'(|{awaddr, awvalid, awlen, awsize, awburst, wdata, wstrb, wvalid, wlast,
                   bready, rd_en, rd_addr, done, err}), 0);
        mon_en = 1'b0;
        start_write = 0; awready = 0; wready = 0; bvalid = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        run_vec(vr, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
